// File: rtl/pulse_train_sched.sv
// rtl/pulse_train_sched.sv - frame-periodic multi-channel launch pulse scheduler
// Staged per-channel delay/width, shadowed at ARM, replayed every frame for a burst.
module pulse_train_sched #(
    parameter int NCH = 4,
    parameter int CW  = 36
) (
    input  logic                     clk_Delay,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     cfg_we,
    input  logic [$clog2(NCH)-1:0]   cfg_ch,
    input  logic [CW-1:0]            cfg_delay,
    input  logic [CW-1:0]            cfg_width,
    input  logic [CW-1:0]            period,
    input  logic [15:0]              n_frames,
    output logic [NCH-1:0]           ch_out,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err,
    output logic [15:0]              frame_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] t;
    logic [CW-1:0] stg_delay [NCH];
    logic [CW-1:0] stg_width [NCH];
    logic [CW-1:0] sh_delay  [NCH];
    logic [CW-1:0] sh_width  [NCH];
    logic [CW-1:0] sh_period;
    logic [15:0]   sh_nframes;
    logic [NCH-1:0] hit;
    logic [NCH-1:0] win;
    logic [CW:0]    win_end [NCH];

    logic frame_wrap;
    logic last_frame;

    // Window end is computed one bit wider so delay+width can never wrap into a short window.
    for (genvar k = 0; k < NCH; k++) begin : g_win
        assign win_end[k] = {1'b0, sh_delay[k]} + {1'b0, sh_width[k]};
        assign win[k]     = (t >= sh_delay[k]) && ({1'b0, t} < win_end[k]);
    end

    assign frame_wrap = (t == sh_period - CW'(1));
    assign last_frame = (sh_nframes != 16'd0) &&
                        (({1'b0, frame_cnt} + 17'd1) == {1'b0, sh_nframes});
    assign busy       = (state != IDLE);

    always_ff @(posedge clk_Delay or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            t          <= '0;
            frame_cnt  <= '0;
            ch_out     <= '0;
            hit        <= '0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            sh_period  <= '0;
            sh_nframes <= '0;
            for (int k = 0; k < NCH; k++) begin
                stg_delay[k] <= '0;
                stg_width[k] <= '0;
                sh_delay[k]  <= '0;
                sh_width[k]  <= '0;
            end
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            if (cfg_we && (int'(cfg_ch) < NCH)) begin
                stg_delay[cfg_ch] <= cfg_delay;
                stg_width[cfg_ch] <= cfg_width;
            end
            case (state)
                IDLE: begin
                    ch_out <= '0;
                    hit    <= '0;
                    if (start && !abort) begin
                        if (period != '0) begin
                            state <= ARM;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ARM: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        for (int k = 0; k < NCH; k++) begin
                            sh_delay[k] <= stg_delay[k];
                            sh_width[k] <= stg_width[k];
                        end
                        sh_period  <= period;
                        sh_nframes <= n_frames;
                        frame_cnt  <= '0;
                        t          <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state  <= IDLE;
                        ch_out <= '0;
                        hit    <= '0;
                    end else begin
                        // Two-stage launch: window match, then registered output level.
                        hit    <= win;
                        ch_out <= hit;
                        if (frame_wrap) begin
                            t <= '0;
                            if (frame_cnt != 16'hFFFF) begin
                                frame_cnt <= frame_cnt + 16'd1;
                            end
                            if (last_frame) begin
                                state  <= IDLE;
                                ch_out <= '0;
                                hit    <= '0;
                                done   <= 1'b1;
                            end
                        end else begin
                            t <= t + CW'(1);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    ch_out <= '0;
                    hit    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_train_sched.sv
// tb/tb_pulse_train_sched.sv - directed vector bench for pulse_train_sched
module tb_pulse_train_sched;

    logic        clk_Delay;
    logic        rst;
    logic        start;
    logic        abort;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [35:0] cfg_delay;
    logic [35:0] cfg_width;
    logic [35:0] period;
    logic [15:0] n_frames;
    logic [3:0]  ch_out;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic [15:0] frame_cnt;

    int checks;
    int errors;

    pulse_train_sched #(.NCH(4), .CW(36)) dut (
        .clk_Delay (clk_Delay),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_delay (cfg_delay),
        .cfg_width (cfg_width),
        .period    (period),
        .n_frames  (n_frames),
        .ch_out    (ch_out),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err),
        .frame_cnt (frame_cnt)
    );

    initial begin
        clk_Delay = 1'b0;
        forever #5 clk_Delay = ~clk_Delay;
    end

    typedef struct {
        int          ch;
        logic [35:0] d;
        logic [35:0] w;
        logic [35:0] p;
        logic [15:0] nf;
        int          rise;
        int          high;
        int          done_at;
        int          fc;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cfg_write(input int ch, input logic [35:0] d, input logic [35:0] w);
        @(negedge clk_Delay);
        cfg_we    = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_delay = d;
        cfg_width = w;
        @(negedge clk_Delay);
        cfg_we    = 1'b0;
    endtask

    // Leaves the bench at the observation point just after edge E0.
    task automatic fire(input logic [35:0] p, input logic [15:0] nf);
        @(negedge clk_Delay);
        period   = p;
        n_frames = nf;
        start    = 1'b1;
        @(negedge clk_Delay);
        start    = 1'b0;
    endtask

    task automatic run_vec(input int ch, output int rise, output int high,
                           output int done_at, output int fc);
        rise    = -1;
        high    = 0;
        done_at = -1;
        for (int n = 1; n <= 500; n++) begin
            @(negedge clk_Delay);
            if (ch_out[ch]) begin
                high++;
                if (rise < 0) rise = n;
            end
            if (done) begin
                done_at = n;
                break;
            end
        end
        fc = int'(frame_cnt);
    endtask

    int r, h, da, fc, rises, quiet;
    logic prev, done_seen;

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_delay = '0;
        cfg_width = '0;
        period    = '0;
        n_frames  = '0;

        vt[0] = '{0, 36'd5, 36'd3,  36'd20, 16'd2, 8,  6,  41, 2};
        vt[1] = '{2, 36'd0, 36'd4,  36'd8,  16'd3, 3,  12, 25, 3};
        vt[2] = '{3, 36'd2, 36'd10, 36'd8,  16'd2, 5,  10, 17, 2};
        vt[3] = '{1, 36'd0, 36'd0,  36'd6,  16'd1, -1, 0,  7,  1};
        vt[4] = '{1, 36'd9, 36'd2,  36'd9,  16'd1, -1, 0,  10, 1};
        vt[5] = '{0, 36'd0, 36'd1,  36'd1,  16'd4, 3,  2,  5,  4};
        vt[6] = '{0, 36'd1, 36'hF_FFFF_FFFF, 36'd4, 16'd1, 4, 1, 5, 1};

        repeat (2) @(negedge clk_Delay);
        chk("reset ch_out", 64'(ch_out), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset cfg_err", 64'(cfg_err), 64'd0);
        chk("reset frame_cnt", 64'(frame_cnt), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            cfg_write(vt[i].ch, vt[i].d, vt[i].w);
            fire(vt[i].p, vt[i].nf);
            run_vec(vt[i].ch, r, h, da, fc);
            chk($sformatf("vec%0d rise", i), 64'(r), 64'(vt[i].rise));
            chk($sformatf("vec%0d high", i), 64'(h), 64'(vt[i].high));
            chk($sformatf("vec%0d done_at", i), 64'(da), 64'(vt[i].done_at));
            chk($sformatf("vec%0d frame_cnt", i), 64'(fc), 64'(vt[i].fc));
            @(negedge clk_Delay);
            chk($sformatf("vec%0d idle", i), 64'({busy, ch_out}), 64'd0);
        end

        // Zero period rejected with a single cfg_err pulse
        fire(36'd0, 16'd1);
        chk("perr pulse", 64'(cfg_err), 64'd1);
        chk("perr busy", 64'(busy), 64'd0);
        @(negedge clk_Delay);
        chk("perr one cycle", 64'({cfg_err, busy, ch_out}), 64'd0);

        // Abort together with start in IDLE stays idle
        @(negedge clk_Delay);
        period = 36'd10; start = 1'b1; abort = 1'b1;
        @(negedge clk_Delay);
        start = 1'b0; abort = 1'b0;
        @(negedge clk_Delay);
        chk("abort+start idle", 64'({busy, cfg_err}), 64'd0);

        // Truncated channel in continuous mode: two cycles per frame
        cfg_write(1, 36'd18, 36'd6);
        fire(36'd20, 16'd0);
        h = 0; rises = 0; prev = 1'b0;
        for (int n = 1; n <= 62; n++) begin
            @(negedge clk_Delay);
            if (ch_out[1]) h++;
            if (ch_out[1] && !prev) rises++;
            prev = ch_out[1];
        end
        chk("trunc high", 64'(h), 64'd6);
        chk("trunc rises", 64'(rises), 64'd3);
        abort = 1'b1;
        @(negedge clk_Delay);
        abort = 1'b0;
        chk("trunc abort idle", 64'({busy, ch_out}), 64'd0);

        // Continuous burst aborted after 35 RUN cycles
        cfg_write(0, 36'd5, 36'd3);
        fire(36'd10, 16'd0);
        done_seen = 1'b0;
        for (int n = 1; n <= 35; n++) begin
            @(negedge clk_Delay);
            if (done) done_seen = 1'b1;
        end
        abort = 1'b1;
        @(negedge clk_Delay);
        abort = 1'b0;
        if (done) done_seen = 1'b1;
        chk("cont abort busy", 64'(busy), 64'd0);
        chk("cont abort ch_out", 64'(ch_out), 64'd0);
        chk("cont abort frame_cnt", 64'(frame_cnt), 64'd3);
        chk("cont abort no done", 64'(done_seen), 64'd0);

        // Abort on the completion edge wins
        fire(36'd4, 16'd1);
        for (int n = 1; n <= 4; n++) @(negedge clk_Delay);
        abort = 1'b1;
        @(negedge clk_Delay);
        abort = 1'b0;
        chk("abort prio done", 64'(done), 64'd0);
        chk("abort prio busy", 64'(busy), 64'd0);
        chk("abort prio frame_cnt", 64'(frame_cnt), 64'd0);

        // Mid-run config write and start are ignored by the running burst
        fire(36'd20, 16'd2);
        rises = 0; prev = 1'b0; da = -1; r = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk_Delay);
            if (ch_out[0] && !prev) begin
                rises++;
                if (rises == 2) r = n;
            end
            prev = ch_out[0];
            if (n == 10) begin cfg_we = 1'b1; cfg_ch = 2'd0; cfg_delay = 36'd2; cfg_width = 36'd3; end
            if (n == 11) cfg_we = 1'b0;
            if (n == 15) start = 1'b1;
            if (n == 16) start = 1'b0;
            if (done) begin da = n; break; end
        end
        chk("shadow 2nd rise", 64'(r), 64'd28);
        chk("shadow done_at", 64'(da), 64'd41);
        fire(36'd20, 16'd1);
        run_vec(0, r, h, da, fc);
        chk("new delay rise", 64'(r), 64'd5);

        // Asynchronous reset while a channel is high
        cfg_write(0, 36'd0, 36'd10);
        fire(36'd20, 16'd0);
        r = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk_Delay);
            if (ch_out[0]) begin r = n; break; end
        end
        chk("pre-reset high", 64'(r), 64'd3);
        #2 rst = 1'b1;
        #1;
        chk("async rst ch_out", 64'(ch_out), 64'd0);
        chk("async rst busy", 64'(busy), 64'd0);
        @(negedge clk_Delay);
        rst = 1'b0;
        quiet = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk_Delay);
            if (busy || done || cfg_err || ch_out != 4'd0) quiet++;
        end
        chk("post-reset quiet", 64'(quiet), 64'd0);
        fire(36'd5, 16'd1);
        quiet = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk_Delay);
            if (ch_out != 4'd0) quiet++;
        end
        chk("staging cleared", 64'(quiet), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
